mem_access: RTL and testbench

- MEM stage of the cqu_mips five-stage pipeline; sits between execute and write_back.
- Issues loads and stores to the data memory over a req/ack handshake and performs byte-lane alignment and sign/zero extension.
- Detects misaligned accesses and bus timeouts.
- Registers the MEM/WB boundary (final_result, write_reg_out, reg_write_final, mem_to_reg_final) consumed by write_back.

---
 rtl/mem_access_pkg.sv | 44 ++++
 rtl/mem_access_if.sv | 35 +++
 rtl/mem_access_align.sv | 56 +++++
 rtl/mem_access.sv | 187 ++++++++++++++++++
 tb/tb_mem_access.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings and record types for the MEM stage of the cqu_mips pipeline.
// Holds the access-size codes, the MEM FSM state codes and the latched request / MEM-WB layouts.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] MS_IDLE = 2'b00;
    localparam logic [1:0] MS_REQ  = 2'b01;
    localparam logic [1:0] MS_HOLD = 2'b10;

    // Everything needed to drive the bus and finish the instruction once ack arrives.
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [1:0]  size;
        logic        is_unsigned;
        logic [4:0]  write_reg;
        logic        reg_write;
        logic        mem_to_reg;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  write_reg;
        logic        reg_write;
        logic        mem_to_reg;
    } mem_wb_t;

    // Size code 2'b11 behaves as a word access.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lsb[0];
            default: bad = (lsb != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
// dmem_req is the valid: once raised, dmem_we/addr/wstrb/wdata hold steady until a rising edge
// samples dmem_ack high; dmem_rdata is only meaningful in that same cycle. Ack may coincide with
// the first request cycle.
interface mem_access_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wstrb,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wstrb,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );

endinterface

// File: rtl/mem_access_align.sv
// Byte-lane steering for data-memory accesses: store strobes/lane replication and
// load lane selection with sign/zero extension. Purely combinational so a cache can reuse it.
module mem_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_addr_i,
    input  logic [31:0] store_data_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    input  logic [1:0]  ld_size_i,
    input  logic        ld_unsigned_i,
    input  logic [1:0]  ld_addr_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        wstrb_o = 4'b1111;
        wdata_o = store_data_i;
        case (st_size_i)
            SZ_BYTE: begin
                wstrb_o = 4'b0001 << st_addr_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            SZ_HALF: begin
                wstrb_o = st_addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{store_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (ld_addr_i)
            2'd0:    ld_byte = rdata_i[7:0];
            2'd1:    ld_byte = rdata_i[15:8];
            2'd2:    ld_byte = rdata_i[23:16];
            default: ld_byte = rdata_i[31:24];
        endcase
        ld_half = ld_addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        ld_data_o = rdata_i;
        case (ld_size_i)
            SZ_BYTE: ld_data_o = {{24{~ld_unsigned_i & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data_o = {{16{~ld_unsigned_i & ld_half[15]}}, ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM stage: issues loads/stores over the dmem req/ack bus, aligns data, flags misaligned
// accesses and bus timeouts, and owns the MEM/WB pipeline register read by write_back.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid,
    input  logic [31:0]         alu_result,
    input  logic [31:0]         store_data,
    input  logic [4:0]          write_reg,
    input  logic                reg_write,
    input  logic                mem_to_reg,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [1:0]          mem_size,
    input  logic                mem_unsigned,
    input  logic                stall_in,
    output logic                stall_out,
    mem_access_if.master        dmem,
    output logic [31:0]         final_result,
    output logic [4:0]          write_reg_out,
    output logic                reg_write_final,
    output logic                mem_to_reg_final,
    output logic                addr_err,
    output logic                bus_err,
    output logic [31:0]         err_addr,
    output logic [1:0]          dbg_state_o
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    mem_req_t    req_q, req_d;
    mem_wb_t     wb_q, wb_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] hold_q, hold_d;
    logic        addr_err_q, addr_err_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] err_addr_q, err_addr_d;

    logic        is_mem;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;
    logic [31:0] rsp_data;

    mem_align u_align (
        .st_size_i     (mem_size),
        .st_addr_i     (alu_result[1:0]),
        .store_data_i  (store_data),
        .wstrb_o       (st_wstrb),
        .wdata_o       (st_wdata),
        .ld_size_i     (req_q.size),
        .ld_unsigned_i (req_q.is_unsigned),
        .ld_addr_i     (req_q.addr[1:0]),
        .rdata_i       (dmem.dmem_rdata),
        .ld_data_o     (ld_data)
    );

    // Stores retire with the address as their result and never write the register file.
    function automatic mem_wb_t commit(input mem_req_t r, input logic [31:0] value);
        mem_wb_t w;
        w.result     = value;
        w.write_reg  = r.write_reg;
        w.reg_write  = r.reg_write & ~r.we;
        w.mem_to_reg = r.mem_to_reg & ~r.we;
        return w;
    endfunction

    assign is_mem   = mem_read | mem_write;
    assign rsp_data = req_q.we ? req_q.addr : ld_data;

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        wb_d       = wb_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        addr_err_d = 1'b0;
        bus_err_d  = 1'b0;
        err_addr_d = err_addr_q;

        case (state_q)
            MS_IDLE: begin
                if (!stall_in) begin
                    // Default for an empty slot or a memory op: a bubble in MEM/WB.
                    wb_d.reg_write  = 1'b0;
                    wb_d.mem_to_reg = 1'b0;
                    if (ex_valid && !is_mem) begin
                        wb_d.result    = alu_result;
                        wb_d.write_reg = write_reg;
                        wb_d.reg_write = reg_write;
                    end else if (ex_valid && misaligned(mem_size, alu_result[1:0])) begin
                        addr_err_d = 1'b1;
                        err_addr_d = alu_result;
                    end else if (ex_valid) begin
                        state_d           = MS_REQ;
                        cnt_d             = 8'd0;
                        req_d.addr        = alu_result;
                        req_d.we          = mem_write;
                        req_d.size        = mem_size;
                        req_d.is_unsigned = mem_unsigned;
                        req_d.write_reg   = write_reg;
                        req_d.reg_write   = reg_write;
                        req_d.mem_to_reg  = mem_to_reg;
                        req_d.wstrb       = mem_write ? st_wstrb : 4'b0000;
                        req_d.wdata       = st_wdata;
                    end
                end
            end

            MS_REQ: begin
                if (dmem.dmem_ack) begin
                    if (!stall_in) begin
                        wb_d    = commit(req_q, rsp_data);
                        state_d = MS_IDLE;
                    end else begin
                        hold_d  = rsp_data;
                        state_d = MS_HOLD;
                    end
                end else if (cnt_q == TO_LAST) begin
                    bus_err_d  = 1'b1;
                    err_addr_d = req_q.addr;
                    state_d    = MS_IDLE;
                    if (!stall_in) begin
                        wb_d.reg_write  = 1'b0;
                        wb_d.mem_to_reg = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            MS_HOLD: begin
                if (!stall_in) begin
                    wb_d    = commit(req_q, hold_q);
                    state_d = MS_IDLE;
                end
            end

            default: state_d = MS_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= MS_IDLE;
            req_q      <= '0;
            wb_q       <= '0;
            cnt_q      <= 8'd0;
            hold_q     <= 32'd0;
            addr_err_q <= 1'b0;
            bus_err_q  <= 1'b0;
            err_addr_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            wb_q       <= wb_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            addr_err_q <= addr_err_d;
            bus_err_q  <= bus_err_d;
            err_addr_q <= err_addr_d;
        end
    end

    // Bus outputs come straight from registers, so async reset drops dmem_req at once.
    assign dmem.dmem_req   = (state_q == MS_REQ);
    assign dmem.dmem_we    = dmem.dmem_req & req_q.we;
    assign dmem.dmem_addr  = {req_q.addr[31:2], 2'b00};
    assign dmem.dmem_wstrb = req_q.wstrb;
    assign dmem.dmem_wdata = req_q.wdata;

    assign stall_out        = (state_q != MS_IDLE);
    assign final_result     = wb_q.result;
    assign write_reg_out    = wb_q.write_reg;
    assign reg_write_final  = wb_q.reg_write;
    assign mem_to_reg_final = wb_q.mem_to_reg;
    assign addr_err         = addr_err_q;
    assign bus_err          = bus_err_q;
    assign err_addr         = err_addr_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a vector table for single transactions plus
// hand-written sequences for timeout, stall during ack, reset mid-request and IDLE stall.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic [31:0] alu_result = '0;
  logic [31:0] store_data = '0;
  logic [4:0]  write_reg = '0;
  logic        reg_write = 1'b0;
  logic        mem_to_reg = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  mem_size = '0;
  logic        mem_unsigned = 1'b0;
  logic        stall_in = 1'b0;
  logic        stall_out;
  logic [31:0] final_result;
  logic [4:0]  write_reg_out;
  logic        reg_write_final;
  logic        mem_to_reg_final;
  logic        addr_err;
  logic        bus_err;
  logic [31:0] err_addr;
  logic [1:0]  dbg_state;

  mem_access_if dmem_if ();

  mem_access #(.TIMEOUT(64)) dut (
    .clk              (clk),
    .rst              (rst),
    .ex_valid         (ex_valid),
    .alu_result       (alu_result),
    .store_data       (store_data),
    .write_reg        (write_reg),
    .reg_write        (reg_write),
    .mem_to_reg       (mem_to_reg),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_size         (mem_size),
    .mem_unsigned     (mem_unsigned),
    .stall_in         (stall_in),
    .stall_out        (stall_out),
    .dmem             (dmem_if.master),
    .final_result     (final_result),
    .write_reg_out    (write_reg_out),
    .reg_write_final  (reg_write_final),
    .mem_to_reg_final (mem_to_reg_final),
    .addr_err         (addr_err),
    .bus_err          (bus_err),
    .err_addr         (err_addr),
    .dbg_state_o      (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] sd;
    logic [4:0]  wr;
    logic        rw;
    logic        rd;
    logic        wrt;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] rdata;
    int          delay;
    logic [31:0] exp_res;
    logic        exp_rwf;
    logic        exp_aerr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[15];

  // Driver tasks
  task automatic drive_ex(input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] wr,
                          input logic rw, input logic rd, input logic wrt,
                          input logic [1:0] size, input logic uns);
    ex_valid     = 1'b1;
    alu_result   = addr;
    store_data   = sd;
    write_reg    = wr;
    reg_write    = rw;
    mem_to_reg   = rd;
    mem_read     = rd;
    mem_write    = wrt;
    mem_size     = size;
    mem_unsigned = uns;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int stall_cnt;
    @(negedge clk);
    drive_ex(v.addr, v.sd, v.wr, v.rw, v.rd, v.wrt, v.size, v.uns);
    @(negedge clk);
    ex_valid = 1'b0;
    if (!(v.rd || v.wrt)) begin
      check($sformatf("v%0d_result", idx), final_result, v.exp_res);
      check($sformatf("v%0d_write_reg", idx), 32'(write_reg_out), 32'(v.wr));
      check($sformatf("v%0d_reg_write", idx), 32'(reg_write_final), 32'(v.exp_rwf));
      check($sformatf("v%0d_mem_to_reg", idx), 32'(mem_to_reg_final), 32'd0);
      check($sformatf("v%0d_stall_out", idx), 32'(stall_out), 32'd0);
      return;
    end
    if (v.exp_aerr) begin
      check($sformatf("v%0d_addr_err", idx), 32'(addr_err), 32'd1);
      check($sformatf("v%0d_err_addr", idx), err_addr, v.addr);
      check($sformatf("v%0d_no_req", idx), 32'(dmem_if.dmem_req), 32'd0);
      check($sformatf("v%0d_bubble", idx), 32'(reg_write_final), 32'd0);
      check($sformatf("v%0d_stay_idle", idx), 32'(stall_out), 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_addr_err_pulse", idx), 32'(addr_err), 32'd0);
      check($sformatf("v%0d_err_addr_hold", idx), err_addr, v.addr);
      return;
    end
    check($sformatf("v%0d_req", idx), 32'(dmem_if.dmem_req), 32'd1);
    check($sformatf("v%0d_we", idx), 32'(dmem_if.dmem_we), 32'(v.wrt));
    check($sformatf("v%0d_wstrb", idx), 32'(dmem_if.dmem_wstrb), 32'(v.exp_strb));
    check($sformatf("v%0d_wdata", idx), dmem_if.dmem_wdata, v.exp_wdata);
    check($sformatf("v%0d_bubble", idx), 32'(reg_write_final), 32'd0);
    exp_q.push_back(v.exp_res);
    stall_cnt = 0;
    for (int c = 0; c < v.delay; c++) begin
      if (stall_out) stall_cnt++;
      check($sformatf("v%0d_addr_c%0d", idx, c), dmem_if.dmem_addr, {v.addr[31:2], 2'b00});
      @(negedge clk);
    end
    check($sformatf("v%0d_addr", idx), dmem_if.dmem_addr, {v.addr[31:2], 2'b00});
    if (stall_out) stall_cnt++;
    dmem_if.dmem_ack   = 1'b1;
    dmem_if.dmem_rdata = v.rdata;
    @(negedge clk);
    dmem_if.dmem_ack   = 1'b0;
    dmem_if.dmem_rdata = '0;
    check($sformatf("v%0d_stall_cycles", idx), 32'(stall_cnt), 32'(v.delay + 1));
    check($sformatf("v%0d_result", idx), final_result, exp_q.pop_front());
    check($sformatf("v%0d_reg_write", idx), 32'(reg_write_final), 32'(v.exp_rwf));
    check($sformatf("v%0d_mem_to_reg", idx), 32'(mem_to_reg_final), 32'(v.rd && !v.wrt));
    check($sformatf("v%0d_write_reg", idx), 32'(write_reg_out), 32'(v.wr));
    check($sformatf("v%0d_idle", idx), 32'(stall_out), 32'd0);
  endtask

  initial begin
    int cnt;
    dmem_if.dmem_ack   = 1'b0;
    dmem_if.dmem_rdata = '0;

    //           addr          sd            wr    rw rd wr size     u rdata         dly res           rwf ae strb     wdata
    vecs[0]  = '{32'h0000_1234, 32'h0,        5'd8,  1, 0, 0, SZ_WORD, 0, 32'h0,        0, 32'h0000_1234, 1, 0, 4'b0000, 32'h0};
    vecs[1]  = '{32'h0000_0103, 32'h0,        5'd9,  1, 1, 0, SZ_BYTE, 0, 32'h80FF_0000, 3, 32'hFFFF_FF80, 1, 0, 4'b0000, 32'h0};
    vecs[2]  = '{32'h0000_0103, 32'h0,        5'd9,  1, 1, 0, SZ_BYTE, 1, 32'h80FF_0000, 3, 32'h0000_0080, 1, 0, 4'b0000, 32'h0};
    vecs[3]  = '{32'h0000_0202, 32'h0000_ABCD, 5'd0,  0, 0, 1, SZ_HALF, 0, 32'h0,        0, 32'h0000_0202, 0, 0, 4'b1100, 32'hABCD_ABCD};
    vecs[4]  = '{32'h0000_0401, 32'h1234_5678, 5'd0,  0, 0, 1, SZ_BYTE, 0, 32'h0,        1, 32'h0000_0401, 0, 0, 4'b0010, 32'h7878_7878};
    vecs[5]  = '{32'h0000_0500, 32'hDEAD_BEEF, 5'd0,  0, 0, 1, SZ_WORD, 0, 32'h0,        2, 32'h0000_0500, 0, 0, 4'b1111, 32'hDEAD_BEEF};
    vecs[6]  = '{32'h0000_0602, 32'h0,        5'd10, 1, 1, 0, SZ_HALF, 0, 32'h8001_7FFF, 0, 32'hFFFF_8001, 1, 0, 4'b0000, 32'h0};
    vecs[7]  = '{32'h0000_0600, 32'h0,        5'd11, 1, 1, 0, SZ_HALF, 1, 32'h8001_FFFE, 1, 32'h0000_FFFE, 1, 0, 4'b0000, 32'h0};
    vecs[8]  = '{32'h0000_0700, 32'h0,        5'd12, 1, 1, 0, SZ_WORD, 0, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 1, 0, 4'b0000, 32'h0};
    vecs[9]  = '{32'h0000_0101, 32'h0,        5'd13, 1, 1, 0, SZ_BYTE, 0, 32'h0000_7F00, 0, 32'h0000_007F, 1, 0, 4'b0000, 32'h0};
    vecs[10] = '{32'h0000_0301, 32'h0,        5'd14, 1, 1, 0, SZ_WORD, 0, 32'h0,        0, 32'h0,        0, 1, 4'b0000, 32'h0};
    vecs[11] = '{32'h0000_0203, 32'h0,        5'd15, 1, 1, 0, SZ_HALF, 0, 32'h0,        0, 32'h0,        0, 1, 4'b0000, 32'h0};
    vecs[12] = '{32'h0000_0002, 32'h1,        5'd0,  0, 0, 1, SZ_WORD, 0, 32'h0,        0, 32'h0,        0, 1, 4'b0000, 32'h0};
    vecs[13] = '{32'h0000_BEEF, 32'h0,        5'd7,  0, 0, 0, SZ_WORD, 0, 32'h0,        0, 32'h0000_BEEF, 0, 0, 4'b0000, 32'h0};
    vecs[14] = '{32'h0000_0403, 32'h0000_00A5, 5'd0,  0, 0, 1, SZ_BYTE, 0, 32'h0,        0, 32'h0000_0403, 0, 0, 4'b1000, 32'hA5A5_A5A5};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req", 32'(dmem_if.dmem_req), 32'd0);
    check("rst_stall_out", 32'(stall_out), 32'd0);
    check("rst_final_result", final_result, 32'd0);
    check("rst_reg_write_final", 32'(reg_write_final), 32'd0);
    check("rst_err_addr", err_addr, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(MS_IDLE));
    rst = 1'b0;

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // Timeout: ack withheld, then a late ack must be ignored
    @(negedge clk);
    drive_ex(32'h0000_0800, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0);
    @(negedge clk);
    ex_valid = 1'b0;
    cnt = 0;
    while (dmem_if.dmem_req && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    check("to_req_cycles", 32'(cnt), 32'd64);
    check("to_bus_err", 32'(bus_err), 32'd1);
    check("to_err_addr", err_addr, 32'h0000_0800);
    check("to_bubble", 32'(reg_write_final), 32'd0);
    dmem_if.dmem_ack   = 1'b1;
    dmem_if.dmem_rdata = 32'h0000_FFFF;
    @(negedge clk);
    dmem_if.dmem_ack   = 1'b0;
    dmem_if.dmem_rdata = '0;
    check("to_bus_err_pulse", 32'(bus_err), 32'd0);
    check("to_late_ack_rw", 32'(reg_write_final), 32'd0);
    check("to_late_ack_idle", 32'(stall_out), 32'd0);
    check("to_err_addr_hold", err_addr, 32'h0000_0800);

    // Ack arrives while downstream is stalled for two cycles
    @(negedge clk);
    drive_ex(32'h0000_0055, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, SZ_WORD, 1'b0);
    @(negedge clk);
    check("hs_add_result", final_result, 32'h0000_0055);
    drive_ex(32'h0000_0900, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0);
    @(negedge clk);
    ex_valid = 1'b0;
    check("hs_req", 32'(dmem_if.dmem_req), 32'd1);
    dmem_if.dmem_ack   = 1'b1;
    dmem_if.dmem_rdata = 32'h1122_3344;
    stall_in = 1'b1;
    @(negedge clk);
    dmem_if.dmem_ack   = 1'b0;
    dmem_if.dmem_rdata = '0;
    check("hs_state_hold", 32'(dbg_state), 32'(MS_HOLD));
    check("hs_stall_out1", 32'(stall_out), 32'd1);
    check("hs_result_frozen1", final_result, 32'h0000_0055);
    check("hs_rw_frozen1", 32'(reg_write_final), 32'd0);
    check("hs_req_dropped", 32'(dmem_if.dmem_req), 32'd0);
    @(negedge clk);
    check("hs_result_frozen2", final_result, 32'h0000_0055);
    check("hs_stall_out2", 32'(stall_out), 32'd1);
    stall_in = 1'b0;
    @(negedge clk);
    check("hs_commit_result", final_result, 32'h1122_3344);
    check("hs_commit_rw", 32'(reg_write_final), 32'd1);
    check("hs_commit_m2r", 32'(mem_to_reg_final), 32'd1);
    check("hs_commit_wr", 32'(write_reg_out), 32'd4);
    check("hs_idle", 32'(stall_out), 32'd0);

    // Reset asserted in the middle of a request
    @(negedge clk);
    drive_ex(32'h0000_0A00, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0);
    @(negedge clk);
    ex_valid = 1'b0;
    check("rr_req", 32'(dmem_if.dmem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rr_req_dropped", 32'(dmem_if.dmem_req), 32'd0);
    check("rr_stall_out", 32'(stall_out), 32'd0);
    check("rr_final_result", final_result, 32'd0);
    check("rr_write_reg_out", 32'(write_reg_out), 32'd0);
    check("rr_reg_write", 32'(reg_write_final), 32'd0);
    check("rr_err_addr", err_addr, 32'd0);
    check("rr_dmem_addr", dmem_if.dmem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dmem_if.dmem_ack   = 1'b1;
    dmem_if.dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_if.dmem_ack   = 1'b0;
    dmem_if.dmem_rdata = '0;
    check("rr_no_completion_rw", 32'(reg_write_final), 32'd0);
    check("rr_no_completion_res", final_result, 32'd0);

    // stall_in in IDLE blocks accept and freezes MEM/WB
    @(negedge clk);
    stall_in = 1'b1;
    drive_ex(32'h0000_0077, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, SZ_WORD, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("is_frozen_result", final_result, 32'd0);
    check("is_frozen_rw", 32'(reg_write_final), 32'd0);
    stall_in = 1'b0;
    @(negedge clk);
    ex_valid = 1'b0;
    check("is_accept_result", final_result, 32'h0000_0077);
    check("is_accept_wr", 32'(write_reg_out), 32'd5);
    check("is_accept_rw", 32'(reg_write_final), 32'd1);

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
